// File: rtl/picorv_vec_mem_arbiter.sv
// picorv_vec_mem_arbiter: arbitrates a CPU and a vector unit onto one memory port.
// Define ARB_TIMEOUT_EN to add a watchdog that completes stalled grants with 32'hDEADBEEF.
module picorv_vec_mem_arbiter #(
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cpu_mem_valid,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,

    input  logic        vec_mem_valid,
    input  logic [31:0] vec_mem_addr,
    input  logic [31:0] vec_mem_wdata,
    input  logic [3:0]  vec_mem_wstrb,
    output logic        vec_mem_ready,
    output logic [31:0] vec_mem_rdata,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  grant,
    output logic        arb_err
);

    localparam int unsigned   SW            = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX          = SW'(STARVE_MAX);
    localparam logic [31:0]   TIMEOUT_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_CPU = 2'b01,
        GNT_VEC = 2'b10
    } state_e;

    state_e        r_state;
    logic [SW-1:0] r_starve_cnt;

    logic        w_sel_valid;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic        w_timeout;
    logic        w_gnt_done;
    logic        w_vec_wins;
    logic        w_ready;
    logic [31:0] w_rdata;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        if (r_state == GNT_CPU) begin
            w_sel_valid = cpu_mem_valid;
            w_sel_addr  = cpu_mem_addr;
            w_sel_wdata = cpu_mem_wdata;
            w_sel_wstrb = cpu_mem_wstrb;
        end else if (r_state == GNT_VEC) begin
            w_sel_valid = vec_mem_valid;
            w_sel_addr  = vec_mem_addr;
            w_sel_wdata = vec_mem_wdata;
            w_sel_wstrb = vec_mem_wstrb;
        end
    end

    // A granted requester that drops valid is abandoned: no ready, straight back to IDLE.
    assign w_gnt_done = !w_sel_valid || mem_ready || w_timeout;
    assign w_vec_wins = vec_mem_valid && !(cpu_mem_valid && (r_starve_cnt == SMAX));

    assign mem_valid = w_sel_valid && !w_timeout;
    assign mem_addr  = w_sel_addr;
    assign mem_wdata = w_sel_wdata;
    assign mem_wstrb = w_sel_wstrb;

    assign w_ready = w_timeout || (mem_ready && w_sel_valid);
    assign w_rdata = w_timeout ? TIMEOUT_RDATA : mem_rdata;

    assign cpu_mem_ready = (r_state == GNT_CPU) && w_ready;
    assign cpu_mem_rdata = (r_state == GNT_CPU) ? w_rdata : '0;
    assign vec_mem_ready = (r_state == GNT_VEC) && w_ready;
    assign vec_mem_rdata = (r_state == GNT_VEC) ? w_rdata : '0;

    assign grant = r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_vec_wins) begin
                        r_state <= GNT_VEC;
                    end else if (cpu_mem_valid) begin
                        r_state <= GNT_CPU;
                    end
                end
                GNT_CPU, GNT_VEC: begin
                    if (w_gnt_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Counts vec grants taken while the CPU is kept waiting.
            if (!cpu_mem_valid) begin
                r_starve_cnt <= '0;
            end else if (r_state == IDLE) begin
                if (w_vec_wins) begin
                    if (r_starve_cnt != SMAX) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end else begin
                    r_starve_cnt <= '0;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] r_wdog;

    assign w_timeout = (r_state != IDLE) && w_sel_valid && (r_wdog == WW'(TIMEOUT_CYCLES));
    assign arb_err   = w_timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdog <= '0;
        end else if ((r_state == IDLE) || w_gnt_done) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign arb_err          = 1'b0;
`endif

endmodule

// File: tb/tb_picorv_vec_mem_arbiter.sv
// Bench for picorv_vec_mem_arbiter: directed transaction table, corner sequences,
// and randomized traffic against a transaction-level ownership model.
`timescale 1ns/1ps
module tb_picorv_vec_mem_arbiter;

    localparam int unsigned STARVE_MAX     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_mem_valid;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        vec_mem_valid;
    logic [31:0] vec_mem_addr;
    logic [31:0] vec_mem_wdata;
    logic [3:0]  vec_mem_wstrb;
    logic        vec_mem_ready;
    logic [31:0] vec_mem_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  grant;
    logic        arb_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    picorv_vec_mem_arbiter #(
        .STARVE_MAX    (STARVE_MAX),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_mem_valid(cpu_mem_valid),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .vec_mem_valid(vec_mem_valid),
        .vec_mem_addr (vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata),
        .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(vec_mem_ready),
        .vec_mem_rdata(vec_mem_rdata),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .grant        (grant),
        .arb_err      (arb_err)
    );

    typedef struct {
        logic        is_vec;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] exp_grant;
        int          exp_ready_cyc;
    } txn_t;

    txn_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_mem_valid = 1'b0;
        cpu_mem_addr  = '0;
        cpu_mem_wdata = '0;
        cpu_mem_wstrb = '0;
        vec_mem_valid = 1'b0;
        vec_mem_addr  = '0;
        vec_mem_wdata = '0;
        vec_mem_wstrb = '0;
        mem_ready     = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'h0);
        check({tag, ".mem_valid"}, 32'(mem_valid), 32'h0);
        check({tag, ".mem_addr"}, mem_addr, 32'h0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        check({tag, ".cpu_ready"}, 32'(cpu_mem_ready), 32'h0);
        check({tag, ".cpu_rdata"}, cpu_mem_rdata, 32'h0);
        check({tag, ".vec_ready"}, 32'(vec_mem_ready), 32'h0);
        check({tag, ".vec_rdata"}, vec_mem_rdata, 32'h0);
        check({tag, ".arb_err"}, 32'(arb_err), 32'h0);
    endtask

    // One isolated transaction; memory answers in the lat-th granted cycle.
    task automatic run_txn(input int idx, input txn_t t);
        string p;
        logic  rdy_exp;
        p = $sformatf("txn%0d", idx);
        if (t.is_vec) begin
            vec_mem_valid = 1'b1;
            vec_mem_addr  = t.addr;
            vec_mem_wdata = t.wdata;
            vec_mem_wstrb = t.wstrb;
        end else begin
            cpu_mem_valid = 1'b1;
            cpu_mem_addr  = t.addr;
            cpu_mem_wdata = t.wdata;
            cpu_mem_wstrb = t.wstrb;
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        check({p, ".c1_grant"}, 32'(grant), 32'h0);
        check({p, ".c1_mem_valid"}, 32'(mem_valid), 32'h0);
        tick();
        for (int c = 2; c <= t.exp_ready_cyc; c++) begin
            mem_ready = (c == t.lat + 1);
            mem_rdata = (c == t.lat + 1) ? t.rdata : $urandom;
            @(negedge clk);
            rdy_exp = (c == t.exp_ready_cyc);
            check($sformatf("%s.c%0d_grant", p, c), 32'(grant), t.exp_grant);
            check($sformatf("%s.c%0d_mem_valid", p, c), 32'(mem_valid), 32'h1);
            check({p, ".mem_addr"}, mem_addr, t.addr);
            check({p, ".mem_wdata"}, mem_wdata, t.wdata);
            check({p, ".mem_wstrb"}, 32'(mem_wstrb), 32'(t.wstrb));
            if (t.is_vec) begin
                check($sformatf("%s.c%0d_vec_ready", p, c), 32'(vec_mem_ready), 32'(rdy_exp));
                check({p, ".cpu_ready"}, 32'(cpu_mem_ready), 32'h0);
                check({p, ".cpu_rdata"}, cpu_mem_rdata, 32'h0);
                if (rdy_exp) check({p, ".vec_rdata"}, vec_mem_rdata, t.rdata);
            end else begin
                check($sformatf("%s.c%0d_cpu_ready", p, c), 32'(cpu_mem_ready), 32'(rdy_exp));
                check({p, ".vec_ready"}, 32'(vec_mem_ready), 32'h0);
                check({p, ".vec_rdata"}, vec_mem_rdata, 32'h0);
                if (rdy_exp) check({p, ".cpu_rdata"}, cpu_mem_rdata, t.rdata);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        check({p, ".bubble_grant"}, 32'(grant), 32'h0);
        check({p, ".bubble_mem_valid"}, 32'(mem_valid), 32'h0);
        check({p, ".bubble_mem_wdata"}, mem_wdata, 32'h0);
        check({p, ".bubble_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          bad;
        int          m_owner;
        int          m_cons;
        int          m_wait;
        logic        sel_v;
        logic        tmo;
        logic        e_rdy;
        logic [31:0] e_rd;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        cpu_done;
        logic        vec_done;

        tbl[0] = '{1'b0, 32'h0000_0190, 32'h0,          4'b0000, 1, 32'h0403_0201, 32'h1, 2};
        tbl[1] = '{1'b1, 32'h0000_0600, 32'h1122_3344,  4'b1111, 1, 32'h0,         32'h2, 2};
        tbl[2] = '{1'b0, 32'h0000_1000, 32'hDEAD_C0DE,  4'b0011, 3, 32'h0,         32'h1, 4};
        tbl[3] = '{1'b1, 32'h0000_2004, 32'h0,          4'b0000, 2, 32'h89AB_CDEF, 32'h2, 3};
        tbl[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          4'b0000, 4, 32'h1357_9BDF, 32'h1, 5};
        tbl[5] = '{1'b1, 32'h0000_0040, 32'hA5A5_A5A5,  4'b1000, 1, 32'h0,         32'h2, 2};

        // Reset: outputs stay zero even with requests and mem_ready active.
        resetn = 1'b0;
        clear_inputs();
        cpu_mem_valid = 1'b1;
        vec_mem_valid = 1'b1;
        mem_ready     = 1'b1;
        mem_rdata     = 32'hCAFE_F00D;
        #2;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_held");
        clear_inputs();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_txn(i, tbl[i]);

        // Simultaneous requests: vec, bubble, cpu.
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h0;
        vec_mem_valid = 1'b1;
        vec_mem_addr  = 32'h190;
        mem_ready     = 1'b1;
        mem_rdata     = 32'h5A5A_0001;
        @(negedge clk);
        check("sim.c1_grant", 32'(grant), 32'h0);
        check("sim.c1_cpu_ready", 32'(cpu_mem_ready), 32'h0);
        check("sim.c1_vec_ready", 32'(vec_mem_ready), 32'h0);
        tick();
        @(negedge clk);
        check("sim.c2_grant", 32'(grant), 32'h2);
        check("sim.c2_mem_addr", mem_addr, 32'h190);
        check("sim.c2_vec_ready", 32'(vec_mem_ready), 32'h1);
        check("sim.c2_cpu_ready", 32'(cpu_mem_ready), 32'h0);
        tick();
        vec_mem_valid = 1'b0;
        @(negedge clk);
        check("sim.c3_grant", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check("sim.c4_grant", 32'(grant), 32'h1);
        check("sim.c4_mem_addr", mem_addr, 32'h0);
        check("sim.c4_cpu_ready", 32'(cpu_mem_ready), 32'h1);
        check("sim.c4_cpu_rdata", cpu_mem_rdata, 32'h5A5A_0001);
        tick();
        clear_inputs();
        @(negedge clk);
        check("sim.c5_grant", 32'(grant), 32'h0);
        tick();

        // Starvation: every 5th grant goes to the CPU, the rest to vec.
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h100;
        vec_mem_valid = 1'b1;
        vec_mem_addr  = 32'h200;
        mem_ready     = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                check($sformatf("starve.c%0d_grant", c), 32'(grant), 32'h0);
                check("starve.bubble_cpu_ready", 32'(cpu_mem_ready), 32'h0);
                check("starve.bubble_vec_ready", 32'(vec_mem_ready), 32'h0);
            end else begin
                check($sformatf("starve.c%0d_grant", c), 32'(grant),
                      ((c / 2) % 5 == 0) ? 32'h1 : 32'h2);
            end
            tick();
        end
        clear_inputs();
        tick();

        // Granted requester withdraws: mem_valid drops at once, no ready.
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h44;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("drop.grant", 32'(grant), 32'h1);
        check("drop.mem_valid_before", 32'(mem_valid), 32'h1);
        tick();
        cpu_mem_valid = 1'b0;
        mem_ready     = 1'b1;
        @(negedge clk);
        check("drop.mem_valid_after", 32'(mem_valid), 32'h0);
        check("drop.cpu_ready", 32'(cpu_mem_ready), 32'h0);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("drop.idle", 32'(grant), 32'h0);
        tick();

        // Reset during GNT_VEC, then resume on the first edge after release.
        vec_mem_valid = 1'b1;
        vec_mem_addr  = 32'h600;
        tick();
        @(negedge clk);
        check("rstmid.grant", 32'(grant), 32'h2);
        tick();
        #2;
        resetn    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_all_zero("rstmid_async");
        @(negedge clk);
        check_all_zero("rstmid_held");
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rstmid.release_grant", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check("rstmid.resume_grant", 32'(grant), 32'h2);
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        check("rstmid.resume_ready", 32'(vec_mem_ready), 32'h1);
        tick();
        clear_inputs();
        tick();

        // Memory never answers.
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h88;
        tick();
        bad = 0;
`ifdef ARB_TIMEOUT_EN
        for (int j = 0; j <= int'(TIMEOUT_CYCLES); j++) begin
            @(negedge clk);
            if (j < int'(TIMEOUT_CYCLES)) begin
                if (grant != 2'b01 || cpu_mem_ready || arb_err || !mem_valid) bad++;
            end else begin
                check("tmo.grant", 32'(grant), 32'h1);
                check("tmo.cpu_ready", 32'(cpu_mem_ready), 32'h1);
                check("tmo.cpu_rdata", cpu_mem_rdata, 32'hDEAD_BEEF);
                check("tmo.arb_err", 32'(arb_err), 32'h1);
                check("tmo.mem_valid", 32'(mem_valid), 32'h0);
            end
            tick();
        end
        check("tmo.early_cycles_bad", 32'(bad), 32'h0);
        cpu_mem_valid = 1'b0;
        @(negedge clk);
        check("tmo.idle", 32'(grant), 32'h0);
        check("tmo.arb_err_pulse", 32'(arb_err), 32'h0);
        tick();
`else
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (grant != 2'b01 || cpu_mem_ready || arb_err || !mem_valid) bad++;
            tick();
        end
        check("stall.cycles_bad", 32'(bad), 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("stall.cpu_ready", 32'(cpu_mem_ready), 32'h1);
        check("stall.cpu_rdata", cpu_mem_rdata, 32'h0BAD_F00D);
        tick();
`endif
        clear_inputs();
        tick();
        tick();

        // Random traffic against an ownership model.
        m_owner  = 0;
        m_cons   = 0;
        m_wait   = 0;
        cpu_done = 1'b0;
        vec_done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cpu_mem_valid && !cpu_done && $urandom_range(0, 19) == 0) begin
                cpu_mem_valid = 1'b0;
            end else if (!cpu_mem_valid || cpu_done) begin
                cpu_mem_valid = ($urandom_range(0, 1) == 1);
                cpu_mem_addr  = $urandom & 32'hFFFF_FFFC;
                cpu_mem_wdata = $urandom;
                cpu_mem_wstrb = 4'($urandom_range(0, 15));
            end
            if (vec_mem_valid && !vec_done && $urandom_range(0, 19) == 0) begin
                vec_mem_valid = 1'b0;
            end else if (!vec_mem_valid || vec_done) begin
                vec_mem_valid = ($urandom_range(0, 1) == 1);
                vec_mem_addr  = $urandom & 32'hFFFF_FFFC;
                vec_mem_wdata = $urandom;
                vec_mem_wstrb = 4'($urandom_range(0, 15));
            end
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            @(negedge clk);

            sel_v   = (m_owner == 1) ? cpu_mem_valid : (m_owner == 2) ? vec_mem_valid : 1'b0;
            e_addr  = (m_owner == 1) ? cpu_mem_addr  : (m_owner == 2) ? vec_mem_addr  : 32'h0;
            e_wdata = (m_owner == 1) ? cpu_mem_wdata : (m_owner == 2) ? vec_mem_wdata : 32'h0;
            e_wstrb = (m_owner == 1) ? cpu_mem_wstrb : (m_owner == 2) ? vec_mem_wstrb : 4'h0;
            tmo     = 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo = (m_owner != 0) && sel_v && (m_wait == int'(TIMEOUT_CYCLES));
`endif
            e_rdy    = tmo || (mem_ready && sel_v);
            e_rd     = tmo ? 32'hDEAD_BEEF : mem_rdata;
            cpu_done = (m_owner == 1) && e_rdy;
            vec_done = (m_owner == 2) && e_rdy;

            check("rnd.grant", 32'(grant), 32'(m_owner));
            check("rnd.mem_valid", 32'(mem_valid), 32'(sel_v && !tmo));
            check("rnd.mem_addr", mem_addr, e_addr);
            check("rnd.mem_wdata", mem_wdata, e_wdata);
            check("rnd.mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
            check("rnd.cpu_ready", 32'(cpu_mem_ready), 32'(cpu_done));
            check("rnd.cpu_rdata", cpu_mem_rdata, (m_owner == 1) ? e_rd : 32'h0);
            check("rnd.vec_ready", 32'(vec_mem_ready), 32'(vec_done));
            check("rnd.vec_rdata", vec_mem_rdata, (m_owner == 2) ? e_rd : 32'h0);
            check("rnd.arb_err", 32'(arb_err), 32'(tmo));

            if (m_owner == 0) begin
                if (vec_mem_valid && !(cpu_mem_valid && m_cons == int'(STARVE_MAX))) begin
                    m_owner = 2;
                    if (m_cons < int'(STARVE_MAX)) m_cons++;
                end else if (cpu_mem_valid) begin
                    m_owner = 1;
                    m_cons  = 0;
                end
                m_wait = 0;
            end else if (!sel_v || mem_ready || tmo) begin
                m_owner = 0;
                m_wait  = 0;
            end else begin
                m_wait++;
            end
            if (!cpu_mem_valid) m_cons = 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picorv_vec_mem_arbiter.md
PICORV_VEC_MEM_ARBITER -- requirements
Module: picorv_vec_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive vector grants while the CPU is requesting.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in cycles (used only under ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
REQ-004 SHALL have the CPU port:
- cpu_mem_valid  in  1  request
- cpu_mem_addr  in  32  byte address
- cpu_mem_wdata  in  32  write data
- cpu_mem_wstrb  in  4  byte enables; 0 = read
- cpu_mem_ready  out  1  completion
- cpu_mem_rdata  out  32  read data
REQ-005 SHALL have the vector port, with the same names, directions and widths as REQ-004 under the prefix vec_mem_.
REQ-006 SHALL have the memory port:
- mem_valid  out  1  request
- mem_addr  out  32  byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  completion
- mem_rdata  in  32  read data
REQ-007 SHALL have the status outputs:
- grant  out  2  one-hot [1]=vec, [0]=cpu
- arb_err  out  1  one-cycle timeout pulse

Function
REQ-008 SHALL implement the FSM states IDLE, GNT_CPU and GNT_VEC.
REQ-009 In IDLE, any requester valid SHALL cause a transition to the winner's GNT state on the next edge; a request is never granted in the same cycle it is first seen.
REQ-010 Winner SHALL be vec when both are valid, except when starve_cnt == STARVE_MAX, in which case the winner is cpu.
REQ-011 starve_cnt SHALL:
- increment on each vec grant made while cpu_mem_valid = 1, saturating at STARVE_MAX
- clear on any cpu grant, or on any cycle with cpu_mem_valid = 0
REQ-012 In a GNT state, mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL combinationally follow the granted port; in IDLE, all four SHALL be 0.
REQ-013 The granted port SHALL receive ready = mem_ready and rdata = mem_rdata combinationally, with zero added latency.
REQ-014 The non-granted port SHALL see ready = 0 and rdata = 0 at all times.
REQ-015 The FSM SHALL return to IDLE on the edge where mem_ready = 1, giving one idle bubble cycle between back-to-back transactions.
REQ-016 Minimum latency from a requester's valid to its ready SHALL be 1 cycle plus the memory latency.
REQ-017 If the granted requester drops valid before mem_ready, the arbiter SHALL deassert mem_valid in the same cycle, return to IDLE, and return no ready.
REQ-018 mem_ready arriving while in IDLE SHALL be ignored.
REQ-019 grant SHALL be registered and equal the FSM state (00 in IDLE).

Reset
REQ-020 Asserting resetn low SHALL immediately force IDLE with:
- starve_cnt = 0 and watchdog = 0
- grant = 00 and arb_err = 0
- all mem_* outputs = 0
- both ready outputs = 0 and both rdata outputs = 0
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction without issuing any ready.
REQ-022 Arbitration SHALL resume on the first clk edge after resetn rises.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: in a GNT state, a watchdog SHALL count the cycles without mem_ready.
REQ-024 When the watchdog reaches TIMEOUT_CYCLES, the arbiter SHALL, in that cycle:
- drive the granted ready = 1 with rdata = 32'hDEADBEEF
- pulse arb_err
- force mem_valid = 0
- then enter IDLE on the next edge
REQ-025 The watchdog SHALL clear on IDLE entry.
REQ-026 Macro ARB_TIMEOUT_EN undefined: no watchdog SHALL be present, arb_err SHALL be tied to 0, and a GNT state SHALL wait indefinitely.

Verification
REQ-027 CPU read alone: cpu addr 0x190, memory word 0x04030201 returned after 1 cycle -> cpu_mem_ready high in cycle 2 after cpu_mem_valid, rdata 0x04030201, grant 01, vec ready 0.
REQ-028 Simultaneous requests: cpu addr 0x000, vec addr 0x190 -> vec served first, then IDLE bubble, then cpu; grant sequence 00,10,00,01.
REQ-029 Starvation: vec valid continuously for 10 transfers, cpu valid continuously -> cpu granted after exactly 4 vec grants; starve_cnt clears.
REQ-030 Vec write: vec_mem_wstrb 1111, data 0x11223344 at addr 600 -> mem_wstrb 1111 and mem_wdata 0x11223344 only while grant = 10.
REQ-031 Reset mid-op: resetn low during GNT_VEC -> all outputs 0 asynchronously and no ready pulse.
REQ-032 With ARB_TIMEOUT_EN and mem_ready stuck at 0: the granted port receives ready with rdata 0xDEADBEEF and arb_err pulses 64 cycles after grant.
